// File: rtl/bit_serial_adder.sv
// Bit-serial ripple adder: one full-adder slice plus a carry flop, WIDTH clocks per add.
// Operands enter and the result leaves over independent valid/ready handshakes.
module bit_serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_q;
  logic [WIDTH-2:0] psum_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, cout_q, out_valid_q;

  logic             s_d, c_d;
  logic [WIDTH-1:0] full_d;

  assign s_d    = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
  assign c_d    = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
  // New bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
  assign full_d = {s_d, psum_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      psum_q      <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      c_q         <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            c_q     <= cin;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          c_q    <= c_d;
          psum_q <= full_d[WIDTH-1:1];
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            sum_q       <= full_d;
            cout_q      <= c_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // rst_n gating keeps in_ready low throughout reset even though state reads IDLE.
  assign in_ready  = rst_n & (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: vector table, hand sequences,
// exhaustive back-to-back sweep and randomized ops against an arithmetic model.
module tb_bit_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
  logic [3:0] a, b, sum;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8, busy8;
  logic [7:0] a8, b8, sum8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy));

  bit_serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .busy(busy8));

  typedef struct {
    logic [3:0] a, b;
    logic       cin;
    logic [3:0] s;
    logic       co;
    int         hold;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Called just after a rising edge with the DUT idle or about to be.
  task automatic run_op(input string nm, input logic [3:0] ta, input logic [3:0] tb_,
                        input logic tc, input logic [3:0] es, input logic ec, input int hold);
    int n, lat, bc;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk({nm, "_rdy_wait"}, n < 20, 1);
    out_ready = (hold == 0);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~ta; b = ~tb_;
    lat = 0; bc = busy ? 1 : 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
      if (busy) bc++;
    end
    chk({nm, "_lat"}, lat, 4);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_cout"}, cout, ec);
    for (int k = 0; k < hold; k++) begin
      in_valid = (k == 0);
      @(posedge clk); #1;
      if (busy) bc++;
      chk({nm, "_hold_vld"}, out_valid, 1);
      chk({nm, "_hold_sum"}, {sum, cout}, {es, ec});
      chk({nm, "_hold_rdy"}, in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_vld_drop"}, out_valid, 0);
    chk({nm, "_idle"}, busy, 0);
    chk({nm, "_busy_cycles"}, bc, 5 + hold);
  endtask

  initial begin
    vec_t tbl[8];
    logic [4:0] e;
    logic [8:0] q[$];
    logic [8:0] ent;
    int cyc, last, idx, ndone, bad_vld;

    tbl[0] = '{4'h3, 4'h5, 1'b0, 4'h8, 1'b0, 0};
    tbl[1] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 0};
    tbl[2] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 0};
    tbl[3] = '{4'h9, 4'h7, 1'b0, 4'h0, 1'b1, 3};
    tbl[4] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 0};
    tbl[5] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1};
    tbl[6] = '{4'h5, 4'hA, 1'b0, 4'hF, 1'b0, 0};
    tbl[7] = '{4'h6, 4'h3, 1'b1, 4'hA, 1'b0, 2};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0;

    repeat (2) @(posedge clk); #1;
    chk("rst_outputs", {out_valid, sum, cout, busy, in_ready}, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_rdy", {in_ready, busy}, 2'b10);

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co, tbl[i].hold);

    // Reset during the second SHIFT cycle of A+6.
    a = 4'hA; b = 4'h6; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("midrst_outputs", {out_valid, sum, cout, busy, in_ready}, '0);
    bad_vld = 0;
    repeat (4) begin @(posedge clk); #1; if (out_valid) bad_vld++; end
    @(negedge clk); rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; if (out_valid) bad_vld++; end
    chk("midrst_no_vld", bad_vld, 0);
    run_op("after_rst", 4'h1, 4'h1, 1'b1, 4'h3, 1'b0, 0);

    // Randomized ops with random backpressure against plain arithmetic.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] ra, rb;
      logic       rc;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      e  = 5'(ra) + 5'(rb) + 5'(rc);
      run_op("rand", ra, rb, rc, e[3:0], e[4], int'($urandom_range(0, 3)));
    end

    // Exhaustive sweep with in_valid and out_ready held high.
    cyc = 0; last = -1; idx = 0; ndone = 0;
    out_ready = 1'b1;
    {a, b, cin} = 9'd0; in_valid = 1'b1;
    while (ndone < 512 && cyc < 5000) begin
      logic acc;
      acc = in_ready && in_valid;
      @(posedge clk); #1; cyc++;
      if (acc) begin
        if (last >= 0) chk("sweep_spacing", cyc - last, 6);
        last = cyc;
        q.push_back(9'({a, b, cin}));
        idx++;
        if (idx < 512) {a, b, cin} = 9'(idx);
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        if (q.size() == 0) chk("sweep_spurious", 1, 0);
        else begin
          ent = q.pop_front();
          e = 5'(ent[8:5]) + 5'(ent[4:1]) + 5'(ent[0]);
          chk($sformatf("sweep_%0h", ent), {cout, sum}, e);
        end
        ndone++;
      end
    end
    in_valid = 1'b0;
    chk("sweep_count", ndone, 512);

    // WIDTH=8 instance: FF+01.
    begin
      int lat8;
      @(posedge clk); #1;
      chk("w8_rdy", in_ready8, 1);
      a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; in_valid8 = 1'b1;
      @(posedge clk); #1; in_valid8 = 1'b0;
      lat8 = 0;
      while (!out_valid8 && lat8 < 30) begin @(posedge clk); #1; lat8++; end
      chk("w8_lat", lat8, 8);
      chk("w8_result", {cout8, sum8}, 9'h100);
      @(posedge clk); #1;
      chk("w8_vld_drop", out_valid8, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bit_serial_adder.md
# bit_serial_adder

Bit-serial ripple adder that is the device-side counterpart of the team's full-adder stimulus/checker benches. It accepts a pair of WIDTH-bit operands plus carry-in over a valid/ready handshake and computes the sum one bit per clock through a single full-adder slice and a carry flip-flop. It returns the WIDTH-bit sum and carry-out over a second valid/ready handshake. It is the sequential, area-minimal sibling of the combinational 4-bit full adder.

## Interface
- WIDTH, 4: operand and sum width in bits; legal range 2 to 32.

- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  input  1  operand request; a, b and cin are valid.
- in_ready  output  1  adder can accept an operand set.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum and cout hold a completed result.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  registered result, (a+b+cin) mod 2^WIDTH.
- cout  output  1  registered result bit WIDTH of a+b+cin.
- busy  output  1  high in SHIFT and DONE.

## Operation
- **States:** IDLE, SHIFT and DONE, with a registered state. Transitions:
  - IDLE → SHIFT on in_valid & in_ready.
  - SHIFT → DONE when bit counter = WIDTH-1.
  - DONE → IDLE on out_ready.
- **IDLE:**
  - in_ready = 1.
  - On acceptance, capture a and b into right-shift registers, load the carry flop with cin, and clear the bit counter.
  - Inputs are sampled only on the accepting edge; changes at any other time are ignored.
- **SHIFT:** each cycle:
  - s = a_sh[0]^b_sh[0]^c.
  - c ← (a_sh[0]&b_sh[0]) | (a_sh[0]&c) | (b_sh[0]&c).
  - s is shifted into the MSB of the partial-sum register.
  - a_sh and b_sh shift right by one, and the counter increments.
- **Final SHIFT cycle:** sum ← the completed partial sum including the last bit, cout ← the final carry, out_valid ← 1.
- **DONE:**
  - out_valid = 1, in_ready = 0.
  - sum and cout are held stable until the out_ready handshake.
  - in_valid is ignored.
- **After the out_ready handshake:** out_valid ← 0. sum and cout keep the last result until the next completion and are meaningful only while out_valid = 1.
- **Overlap:** no pipelining; exactly one operation is in flight.
- **Arithmetic:** unsigned, with no overflow flag beyond cout. With a = b = all-ones and cin = 1, the result is sum = all-ones and cout = 1.
- **Bit counter:** $clog2(WIDTH) bits wide. It wraps only via the state change and is never compared past WIDTH-1.

## Timing
- **Reset (asynchronous, active-low):**
  - Outputs while rst_n = 0: state IDLE, out_valid 0, sum 0, cout 0, busy 0, carry 0, counter 0. in_ready is forced 0 while rst_n = 0 and goes to 1 in the first cycle after release.
  - Reset asserted mid-SHIFT or in DONE aborts the operation and discards partial results. There is no output pulse.
- **Latency:** the accepting edge is E0. out_valid rises on edge E0+WIDTH (4 clocks for WIDTH = 4).
- **Throughput:** with out_ready held high, out_valid is a 1-cycle pulse. The minimum accept-to-accept period is WIDTH+2 cycles: WIDTH in SHIFT, 1 in DONE, 1 in IDLE.
- **Combinational outputs:**
  - in_ready is decoded from state only; it has no combinational path from in_valid or out_ready.
  - busy = (state != IDLE).
- **Simultaneous events:** in_valid arriving during the DONE→IDLE edge is not accepted until the IDLE cycle.

## Test plan
- **Basic add:** reset, then accept a=4'h3, b=4'h5, cin=0 → out_valid on the 4th edge after acceptance with sum=4'h8, cout=0; busy high for exactly 5 cycles.
- **Full carry ripple:** a=4'hF, b=4'hF, cin=1 → sum=4'hF, cout=1. Also a=4'hF, b=4'h0, cin=1 → sum=4'h0, cout=1.
- **Backpressure:** a=4'h9, b=4'h7, cin=0 with out_ready low for 3 cycles after out_valid:
  - out_valid stays 1 and sum=4'h0, cout=1 stay stable.
  - in_ready stays 0, and an in_valid pulse in this window is not accepted.
  - out_valid drops on the edge after out_ready rises.
- **Reset mid-operation:** drop rst_n during the 2nd SHIFT cycle of a=4'hA, b=4'h6:
  - All outputs go to reset values immediately and no out_valid appears.
  - A subsequent a=4'h1, b=4'h1, cin=1 gives sum=4'h3, cout=0.
- **Exhaustive back-to-back:** all 512 {a,b,cin} combinations with in_valid and out_ready held high:
  - Every result matches a+b+cin.
  - Each acceptance is spaced exactly 6 cycles apart for WIDTH=4.
- **WIDTH=8 build:** a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1, with out_valid 8 edges after acceptance.
